command_issuer: RTL

//  Host-side producer of the 32-bit command bus consumed by system_controller. Accepts command

---
 rtl/command_issuer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/command_issuer.sv
// Host-side command issuer: buffers 32-bit command words in a small FIFO and replays each
// one on cmd_data with a paced latch_data strobe, keeping cmd_data stable around every edge.
module command_issuer #(
  parameter int FIFO_AW     = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [31:0]        host_data,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic               flush,
  output logic [31:0]        cmd_data,
  output logic               latch_data,
  output logic               cmd_issued,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [1:0]         fsm_state
);

  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {IDLE, SETUP, ASSERT, GAP} state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       phase_cnt;
  logic [7:0]       phase_load;
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic [FIFO_AW:0] level;
  logic [31:0]      mem [DEPTH];
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;

  // Host handshake: a word transfers on a rising clock edge where host_valid & host_ready;
  // host_data must be stable while host_valid is high, and host_ready never depends on host_valid.
  assign level      = wr_ptr - rd_ptr;
  assign empty      = (level == '0);
  assign full       = level[FIFO_AW];
  assign host_ready = ~full & ~flush;
  assign push       = host_valid & host_ready;
  assign fifo_level = level;
  assign busy       = (state != IDLE) | ~empty;
  assign fsm_state  = state;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    phase_load = 8'd0;
    case (state)
      IDLE: begin
        if (!empty && !flush) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ASSERT;
        phase_load = 8'(HOLD_CYCLES - 1);
      end
      ASSERT: begin
        if (phase_cnt == 8'd0) begin
          state_next = GAP;
          phase_load = 8'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (phase_cnt == 8'd0) begin
          if (!empty && !flush) begin
            pop        = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase_cnt  <= 8'd0;
      latch_data <= 1'b0;
      cmd_issued <= 1'b0;
      cmd_data   <= 32'd0;
    end else begin
      state      <= state_next;
      latch_data <= (state_next == ASSERT);
      cmd_issued <= (state_next == ASSERT) && (state != ASSERT);
      // Counter reloads on every state change so each phase times itself from entry.
      if (state_next != state) begin
        phase_cnt <= phase_load;
      end else if (phase_cnt != 8'd0) begin
        phase_cnt <= phase_cnt - 8'd1;
      end
      if (pop) begin
        cmd_data <= mem[rd_ptr[FIFO_AW-1:0]];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (FIFO_AW + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= host_data;
    end
  end

endmodule
